// File: rtl/chunked_max_streamer.sv
// Captures a frame when in_ready (IDLE), then emits one signed max/argmax per chunk on CHUNKS consecutive cycles.
// Latency: chunk 0 one cycle after acceptance; in_ready low while streaming, so the frame period is CHUNKS+1 cycles.
module chunked_max_streamer #(
    parameter int WIDTH           = 8,
    parameter int LANES           = 4,
    parameter int LANE_IDX_WIDTH  = 2,
    parameter int CHUNKS          = 4,
    parameter int CHUNK_IDX_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH*LANES*CHUNKS-1:0]    in_data,
    output logic                             out_enable,
    output logic signed [WIDTH-1:0]          out_max,
    output logic [LANE_IDX_WIDTH-1:0]        out_argmax,
    output logic [CHUNK_IDX_WIDTH-1:0]       out_chunk,
    output logic                             out_first,
    output logic                             out_last
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [CHUNK_IDX_WIDTH-1:0] LAST_CHUNK = CHUNK_IDX_WIDTH'(CHUNKS - 1);
    localparam logic signed [WIDTH-1:0]    MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                          state;
    state_t                          next_state;
    logic [WIDTH*LANES*CHUNKS-1:0]   frame;
    logic [CHUNK_IDX_WIDTH-1:0]      chunk_cnt;
    logic                            accept;
    logic                            last_chunk;
    logic signed [WIDTH-1:0]         lane_val [LANES];
    logic signed [WIDTH-1:0]         best_val;
    logic [LANE_IDX_WIDTH-1:0]       best_idx;

    assign in_ready   = (state == IDLE);
    assign accept     = in_valid && in_ready;
    assign last_chunk = (chunk_cnt == LAST_CHUNK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = STREAM;
            STREAM:  if (last_chunk) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strict greater-than scanning upward keeps the lowest lane on ties.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_val[l] = frame[(int'(chunk_cnt) * LANES + l) * WIDTH +: WIDTH];
        end
        best_val = lane_val[0];
        best_idx = '0;
        for (int l = 1; l < LANES; l++) begin
            if (lane_val[l] > best_val) begin
                best_val = lane_val[l];
                best_idx = LANE_IDX_WIDTH'(l);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame      <= '0;
            chunk_cnt  <= '0;
            out_enable <= 1'b0;
            out_max    <= MOST_NEG;
            out_argmax <= '0;
            out_chunk  <= '0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
        end else if (state == STREAM) begin
            out_enable <= 1'b1;
            out_max    <= best_val;
            out_argmax <= best_idx;
            out_chunk  <= chunk_cnt;
            out_first  <= (chunk_cnt == '0);
            out_last   <= last_chunk;
            // Counter parks on the last chunk; only a new acceptance rewinds it.
            if (!last_chunk) begin
                chunk_cnt <= chunk_cnt + 1'b1;
            end
        end else begin
            out_enable <= 1'b0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            if (accept) begin
                frame     <= in_data;
                chunk_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/chunked_max_streamer.md
CHUNKED_MAX_STREAMER -- requirements
Module: chunked_max_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each signed element.
REQ-002 SHALL have parameter LANES, default 4: elements per chunk.
REQ-003 SHALL have parameter LANE_IDX_WIDTH, default 2: width of the lane index, clog2(LANES).
REQ-004 SHALL have parameter CHUNKS, default 4: chunks per frame, with CHUNKS >= 2.
REQ-005 SHALL have parameter CHUNK_IDX_WIDTH, default 2: width of the chunk index, clog2(CHUNKS).
REQ-006 SHALL have port clk, input, 1 bit: the only clock; all logic acts on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port in_valid, input, 1 bit: a frame is offered.
REQ-009 SHALL have port in_ready, output, 1 bit: the block can accept a frame.
REQ-010 SHALL have port in_data, input, WIDTH*LANES*CHUNKS bits: the frame; element (chunk k, lane l) is in_data[(k*LANES+l)*WIDTH +: WIDTH], signed.
REQ-011 SHALL have port out_enable, output, 1 bit: qualifies all other out_* ports.
REQ-012 SHALL have port out_max, output, WIDTH bits, signed: maximum value of the current chunk.
REQ-013 SHALL have port out_argmax, output, LANE_IDX_WIDTH bits: lane index of out_max within the chunk.
REQ-014 SHALL have port out_chunk, output, CHUNK_IDX_WIDTH bits: index of the current chunk.
REQ-015 SHALL have port out_first, output, 1 bit: marks chunk 0.
REQ-016 SHALL have port out_last, output, 1 bit: marks chunk CHUNKS-1.

Function
REQ-017 SHALL implement a two-state FSM, IDLE and STREAM; in_ready SHALL be 1 exactly when the state is IDLE (combinational from state).
REQ-018 SHALL accept a frame on a rising edge where in_valid=1 and in_ready=1 (edge E0); it SHALL register in_data into an internal frame register, clear the chunk counter to 0 and go to STREAM.
REQ-019 SHALL ignore in_valid and in_data while in STREAM; the captured frame SHALL NOT change until the next acceptance.
REQ-020 SHALL, at each edge Ek for k=1..CHUNKS in STREAM, register the result for chunk k-1: out_enable=1, out_max, out_argmax, out_chunk=k-1, out_first=(k-1==0), out_last=(k-1==CHUNKS-1).
REQ-021 SHALL therefore hold out_enable high for exactly CHUNKS consecutive cycles, starting one cycle after acceptance, with no gaps.
REQ-022 SHALL compute the chunk maximum by signed comparison over the LANES elements; on ties, out_argmax SHALL be the lowest lane index (strict greater-than scanning upward from lane 0).
REQ-023 SHALL compare within WIDTH-bit signed values with no overflow; the most negative value -2^(WIDTH-1) SHALL be a valid maximum.
REQ-024 SHALL return to IDLE on edge E_CHUNKS; on the next edge, out_enable, out_first and out_last SHALL be 0, while out_max, out_argmax and out_chunk SHALL keep their last values.
REQ-025 SHALL make in_ready 1 in the cycle after E_CHUNKS, so that with in_valid held the next frame is accepted at E_CHUNKS+1 and the frame period is CHUNKS+1 cycles.
REQ-026 SHALL let the chunk counter wrap to 0 only through a new acceptance, never by free-running.
REQ-027 SHALL produce out_* that can drive a downstream serial argmax directly: out_max feeds in, out_argmax feeds in_argmax, out_enable feeds enable, and out_first can be used to clear the downstream block.

Reset
REQ-028 SHALL, while rst=1 (asynchronously, independent of clk), force state=IDLE, chunk counter=0, frame register=0, out_enable=0, out_first=0, out_last=0, out_chunk=0, out_argmax=0 and out_max=-2^(WIDTH-1).
REQ-029 SHALL, when rst is asserted mid-STREAM, abandon the frame with no further out_enable; after release it SHALL show in_ready=1 and the next accepted frame SHALL start at chunk 0.
REQ-030 SHALL not accept a frame while rst=1, and SHALL accept one on the first rising edge after rst deasserts if in_valid=1.

Verification (WIDTH=8, LANES=4, CHUNKS=4)
REQ-031 SHALL be verified for reset/idle: assert rst with no clock edge -> all outputs at REQ-028 values immediately, out_max=-128, in_ready=1.
REQ-032 SHALL be verified for a single frame: chunk0 = {3,-5,7,7}, chunk1 = {-128,-128,-128,-128}, chunk2 = {0,1,2,127}, chunk3 = {-1,-2,-3,-4} -> (max,argmax,chunk) = (7,2,0) with first=1, (-128,0,1), (127,3,2), (-1,0,3) with last=1, on four consecutive cycles starting 1 cycle after acceptance.
REQ-033 SHALL be verified for input ignored while busy: change in_data and pulse in_valid during STREAM -> in_ready=0 and the outputs match the originally captured frame.
REQ-034 SHALL be verified for back-to-back frames: hold in_valid=1 for two frames -> out_enable pattern 1,1,1,1,0,1,1,1,1 and the second out_first occurs 5 cycles after the first.
REQ-035 SHALL be verified for reset mid-stream: assert rst after the chunk-1 output -> out_enable=0 at once and no chunk-2/3 output; re-send the frame after release -> full chunk 0..3 sequence.
REQ-036 SHALL be verified chained with serial_parallel_argmax (MAX_IN_ARGMAX=4), cleared on out_first: global maximum 100 at chunk 2, lane 3, all other elements < 100 -> downstream argmax=11, max=100 after out_last.
